line_mem_ctrl: RTL and testbench
================================

// Module: line_mem_ctrl
// PURPOSE
//  Backing-memory controller directly downstream of the L1 byte cache.
//  - Serves 4-byte line refills (rreq/raddr -> rdata/rvalid).
//  - Absorbs single-byte write-through pulses in a small posted-write FIFO.
//  - Holds the 8 KB byte-addressed main memory array, with programmable access latency.
// PARAMETERS
//  ADDR_W      13   byte address width; memory holds 2**ADDR_W bytes
//  RD_LATENCY  8    cycles from read accept to rvalid; must be >= 1
//  WR_LATENCY  2    cycles per drained write; must be >= 1
//  WBUF_DEPTH  4    posted-write FIFO entries; power of 2
//  INIT_FILE   ""   $readmemh image loaded at time 0; empty string = array left X
// PORTS
//  clk          in   1       clock
//  reset        in   1       reset, synchronous, active-high
//  rreq         in   1       level line-read request, held until rvalid
//  raddr        in   ADDR_W  read address; bits [1:0] ignored (line aligned)
//  wreq         in   1       single-cycle byte write pulse
//  waddr        in   ADDR_W  write byte address, sampled with wreq
//  wdata        in   8       write byte, sampled with wreq
//  rdata        out  32      refill line, little-endian; [7:0] = byte at offset 0
//  rvalid       out  1       one-cycle pulse, rdata valid
//  wbuf_empty   out  1       1 = no posted writes pending
//  wr_overflow  out  1       sticky; a wreq was dropped on a full FIFO
// BEHAVIOUR
//  Reset values
//  - rdata=0, rvalid=0, wbuf_empty=1, wr_overflow=0.
//  - FIFO pointers/count=0, state=IDLE.
//  - Memory array NOT cleared by reset.
//  Write FIFO
//  - wreq pushes {waddr,wdata} when count<WBUF_DEPTH, or when a pop occurs the same cycle.
//  - Otherwise the write is dropped and wr_overflow is set to 1 until reset.
//  - Entries are drained strictly in order.
//  FSM: IDLE, WR_DRAIN, RD_WAIT, RD_RESP
//  - IDLE: if FIFO non-empty -> WR_DRAIN (writes have priority, so a read sees all
//    earlier posted writes). Else if rreq -> RD_WAIT; latch raddr[ADDR_W-1:2] and load
//    the latency counter. The accept edge is edge N.
//  - WR_DRAIN: count WR_LATENCY cycles. On the final cycle write the head byte to
//    mem[addr], pop the FIFO, then return to IDLE.
//  - RD_WAIT: rdata and rvalid update on edge N+RD_LATENCY, and the FSM moves to RD_RESP
//    on that edge. rdata is assembled from mem[{line,2'b00}..{line,2'b11}].
//    A wreq arriving during RD_WAIT is pushed only; it does not alter the line in flight.
//  - RD_RESP: rvalid=1 for exactly this cycle, then the FSM returns to IDLE.
//    rdata holds its value until the next response.
//  Upstream contract
//  - rreq must be low in the cycle after rvalid. If rreq is still high in IDLE, a new
//    read starts.
//  - rreq deasserting during RD_WAIT does not abort the read; rvalid still fires.
//  Other rules
//  - wbuf_empty = (count==0), combinational.
//  - The latency counter width is clog2(max(RD_LATENCY,WR_LATENCY))+1.
//  - Read address covers the top line 0x1FFC..0x1FFF. There is no wrap past the top.
//  - Reset mid-operation aborts any read or drain: no rvalid, FIFO contents discarded,
//    partially drained write not committed.
// TESTING
//  T1 reset:
//   - Assert reset 2 cycles mid-traffic -> all outputs at reset values on the next cycle.
//  T2 refill:
//   - INIT mem[0x040..0x043]=11,22,33,44; hold rreq with raddr=0x041.
//   - Required: rvalid exactly 8 cycles after accept, rdata=0x44332211, rvalid high 1 cycle.
//  T3 RAW ordering:
//   - wreq 0x042<=0xAB, next cycle rreq 0x040.
//   - Required: drain completes first, rdata=0x44AB2211, rvalid at 1+2+1+8 cycles after wreq.
//  T4 overflow:
//   - WR_LATENCY=8; 6 back-to-back wreq to 0x100..0x105, data 1..6.
//   - Required: wr_overflow=1; mem 0x100..0x103=1..4; 0x104/0x105 unchanged.
//   - Required: wbuf_empty=1 after 4 drains.
//  T5 reset during RD_WAIT:
//   - Assert reset 3 cycles after accept -> no rvalid.
//   - Next read of 0x040 returns 0x44332211 after 8 cycles.
//  T6 top line:
//   - INIT mem[0x1FFC..0x1FFF]=DE,AD,BE,EF; rreq raddr=0x1FFF -> rdata=0xEFBEADDE.

Source files
------------

// File: rtl/line_mem_ctrl.sv
// line_mem_ctrl: backing-memory controller behind the L1 byte cache.
// Serves 4-byte line refills, absorbs byte write-throughs in a posted-write
// FIFO, and owns the byte-addressed main memory array.
module line_mem_ctrl #(
    parameter int ADDR_W     = 13,
    parameter int RD_LATENCY = 8,
    parameter int WR_LATENCY = 2,
    parameter int WBUF_DEPTH = 4,
    parameter     INIT_FILE  = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rreq,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              wreq,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              wbuf_empty,
    output logic              wr_overflow
);

    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam int PTR_W   = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int LINE_W  = ADDR_W - 2;

    typedef enum logic [1:0] {IDLE, WR_DRAIN, RD_WAIT, RD_RESP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  lat_cnt;
    logic [LINE_W-1:0] line_q;

    logic [7:0]        mem [0:(2**ADDR_W)-1];

    logic [ADDR_W-1:0] fifo_addr [0:WBUF_DEPTH-1];
    logic [7:0]        fifo_data [0:WBUF_DEPTH-1];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;

    logic              push, pop;
    logic [31:0]       line_word;

    // Offset bits of the read address are don't-care: refills are line aligned.
    logic unused_raddr_lsbs;
    assign unused_raddr_lsbs = ^raddr[1:0];

    // Head entry retires on the last cycle of a drain; a full FIFO still
    // accepts a push in that same cycle since a slot frees up.
    assign pop        = (state == WR_DRAIN) && (lat_cnt == '0);
    assign push       = wreq && ((count < (PTR_W+1)'(WBUF_DEPTH)) || pop);
    assign wbuf_empty = (count == '0);

    assign line_word = {mem[{line_q, 2'b11}], mem[{line_q, 2'b10}],
                        mem[{line_q, 2'b01}], mem[{line_q, 2'b00}]};

    // FIFO storage; contents are don't-care until counted in.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= waddr;
            fifo_data[wr_ptr] <= wdata;
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            wr_overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PTR_W'(WBUF_DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= (rd_ptr == PTR_W'(WBUF_DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
            if (wreq && !push)
                wr_overflow <= 1'b1;
        end
    end

    // Memory array: only drained writes land here; reset leaves it intact
    // and blocks a drain that would complete on the reset edge.
    always_ff @(posedge clk) begin
        if (pop && !reset)
            mem[fifo_addr[rd_ptr]] <= fifo_data[rd_ptr];
    end

    // Control FSM: drains take priority so a read observes every earlier write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            lat_cnt <= '0;
            line_q  <= '0;
            rdata   <= '0;
            rvalid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rvalid <= 1'b0;
                    if (count != '0) begin
                        state   <= WR_DRAIN;
                        lat_cnt <= CNT_W'(WR_LATENCY - 1);
                    end else if (rreq) begin
                        state   <= RD_WAIT;
                        line_q  <= raddr[ADDR_W-1:2];
                        lat_cnt <= CNT_W'(RD_LATENCY - 1);
                    end
                end
                WR_DRAIN: begin
                    if (lat_cnt == '0)
                        state <= IDLE;
                    else
                        lat_cnt <= lat_cnt - CNT_W'(1);
                end
                RD_WAIT: begin
                    if (lat_cnt == '0) begin
                        rdata  <= line_word;
                        rvalid <= 1'b1;
                        state  <= RD_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - CNT_W'(1);
                    end
                end
                RD_RESP: begin
                    rvalid <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    rvalid <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_mem_ctrl.sv
// tb_line_mem_ctrl: directed scenarios plus randomized refill/write traffic
// checked against a byte-array model of main memory.
module tb_line_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        rreq, wreq, rreq_b, wreq_b;
    logic [12:0] raddr, waddr, raddr_b, waddr_b;
    logic [7:0]  wdata, wdata_b;
    logic [31:0] rdata, rdata_b;
    logic        rvalid, wbuf_empty, wr_overflow;
    logic        rvalid_b, wbuf_empty_b, wr_overflow_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] model [0:8191];

    line_mem_ctrl u_dut (
        .clk(clk), .reset(reset), .rreq(rreq), .raddr(raddr),
        .wreq(wreq), .waddr(waddr), .wdata(wdata),
        .rdata(rdata), .rvalid(rvalid), .wbuf_empty(wbuf_empty), .wr_overflow(wr_overflow)
    );

    line_mem_ctrl #(.WR_LATENCY(8)) u_dut8 (
        .clk(clk), .reset(reset), .rreq(rreq_b), .raddr(raddr_b),
        .wreq(wreq_b), .waddr(waddr_b), .wdata(wdata_b),
        .rdata(rdata_b), .rvalid(rvalid_b), .wbuf_empty(wbuf_empty_b), .wr_overflow(wr_overflow_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mline(input logic [12:0] a);
        return {model[{a[12:2], 2'b11}], model[{a[12:2], 2'b10}],
                model[{a[12:2], 2'b01}], model[{a[12:2], 2'b00}]};
    endfunction

    task automatic wr(input logic [12:0] a, input logic [7:0] d);
        waddr = a; wdata = d; wreq = 1'b1;
        tick();
        wreq = 1'b0;
        model[a] = d;
    endtask

    task automatic wr_b(input logic [12:0] a, input logic [7:0] d);
        waddr_b = a; wdata_b = d; wreq_b = 1'b1;
        tick();
        wreq_b = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        while (!wbuf_empty && n < 200) begin tick(); n++; end
        check(tag, wbuf_empty, 1'b1);
        tick();
    endtask

    task automatic wait_empty_b(input string tag);
        int n = 0;
        while (!wbuf_empty_b && n < 400) begin tick(); n++; end
        check(tag, wbuf_empty_b, 1'b1);
        tick();
    endtask

    // Line read on the main DUT; lat counts ticks from raising rreq to rvalid.
    task automatic rd(input string tag, input logic [12:0] a, input logic [31:0] exp, input int exp_lat);
        int lat = 0;
        raddr = a; rreq = 1'b1;
        do begin tick(); lat++; end while (!rvalid && lat < 100);
        rreq = 1'b0;
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_data"}, rdata, exp);
        tick();
        check({tag, "_pulse"}, rvalid, 1'b0);
        check({tag, "_hold"}, rdata, exp);
        tick();
    endtask

    task automatic rd_b(input string tag, input logic [12:0] a, input logic [31:0] exp);
        int lat = 0;
        raddr_b = a; rreq_b = 1'b1;
        do begin tick(); lat++; end while (!rvalid_b && lat < 100);
        rreq_b = 1'b0;
        check({tag, "_lat"}, lat, 9);
        check({tag, "_data"}, rdata_b, exp);
        tick();
    endtask

    initial begin
        logic [31:0] exp;
        logic [12:0] a;
        logic        seen;
        int          n, lat;
        bit          inflight;

        reset = 1'b1;
        rreq = 0; wreq = 0; raddr = 0; waddr = 0; wdata = 0;
        rreq_b = 0; wreq_b = 0; raddr_b = 0; waddr_b = 0; wdata_b = 0;
        tick(); tick();
        check("rst_rdata", rdata, 32'h0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_empty", wbuf_empty, 1'b1);
        check("rst_ovf", wr_overflow, 1'b0);
        check("rst_ovf_b", wr_overflow_b, 1'b0);
        reset = 1'b0;
        tick();

        // Refill latency and byte order.
        wr(13'h040, 8'h11); wr(13'h041, 8'h22); wr(13'h042, 8'h33); wr(13'h043, 8'h44);
        wait_empty("t2_drain");
        rd("t2", 13'h041, 32'h44332211, 9);

        // Posted write must land before the following read is served.
        wr(13'h042, 8'hAB);
        rd("t3", 13'h040, 32'h44AB2211, 12);
        wr(13'h042, 8'h33);
        wait_empty("t3_restore");

        // Overflow on the slow-drain instance.
        for (int i = 0; i < 4; i++) wr_b(13'h104 + 13'(i), 8'hA0 + 8'(i));
        wait_empty_b("t4_pre_drain");
        check("t4_pre_ovf", wr_overflow_b, 1'b0);
        for (int i = 0; i < 6; i++) wr_b(13'h100 + 13'(i), 8'(i + 1));
        check("t4_busy", wbuf_empty_b, 1'b0);
        check("t4_ovf", wr_overflow_b, 1'b1);
        wait_empty_b("t4_drain");
        check("t4_ovf_sticky", wr_overflow_b, 1'b1);
        rd_b("t4_lo", 13'h100, 32'h04030201);
        rd_b("t4_hi", 13'h104, 32'hA3A2A1A0);

        // Reset during RD_WAIT kills the response but keeps memory.
        raddr = 13'h040; rreq = 1'b1;
        tick(); tick(); tick();
        reset = 1'b1; rreq = 1'b0;
        tick(); tick();
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (rvalid) seen = 1'b1;
            tick();
        end
        check("t5_no_rvalid", seen, 1'b0);
        check("t5_rdata_rst", rdata, 32'h0);
        check("t5_ovf_b_rst", wr_overflow_b, 1'b0);
        rd("t5", 13'h040, 32'h44332211, 9);

        // Top line of the array.
        wr(13'h1FFC, 8'hDE); wr(13'h1FFD, 8'hAD); wr(13'h1FFE, 8'hBE); wr(13'h1FFF, 8'hEF);
        wait_empty("t6_drain");
        rd("t6", 13'h1FFF, 32'hEFBEADDE, 9);

        // Randomized traffic over a 64-byte window.
        for (int g = 0; g < 16; g++) begin
            for (int i = 0; i < 4; i++) wr(13'h300 + 13'(g*4 + i), 8'($urandom));
            wait_empty("rnd_pre");
        end
        for (int it = 0; it < 20; it++) begin
            n = $urandom_range(0, 4);
            for (int i = 0; i < n; i++) wr(13'h300 | 13'($urandom_range(0, 63)), 8'($urandom));
            a = 13'h300 | 13'($urandom_range(0, 63));
            exp = mline(a);
            inflight = (n == 0) && ($urandom_range(0, 1) == 1);
            raddr = a; rreq = 1'b1; lat = 0;
            do begin
                tick(); lat++;
                if (inflight && lat == 2) begin
                    waddr = {a[12:2], 2'($urandom)};
                    wdata = 8'($urandom);
                    wreq = 1'b1;
                    model[waddr] = wdata;
                end else begin
                    wreq = 1'b0;
                end
            end while (!rvalid && lat < 100);
            wreq = 1'b0; rreq = 1'b0;
            check("rnd_data", rdata, exp);
            if (n == 0) check("rnd_lat", lat, 9);
            tick();
            check("rnd_pulse", rvalid, 1'b0);
            wait_empty("rnd_drain");
        end

        // Reset in the middle of traffic on both instances.
        for (int i = 0; i < 6; i++) wr_b(13'h180 + 13'(i), 8'(i));
        wr(13'h200, 8'h5A); wr(13'h201, 8'h5B);
        raddr = 13'h040; rreq = 1'b1;
        tick();
        reset = 1'b1; rreq = 1'b0;
        tick(); tick();
        check("t1_rdata", rdata, 32'h0);
        check("t1_rvalid", rvalid, 1'b0);
        check("t1_empty", wbuf_empty, 1'b1);
        check("t1_ovf", wr_overflow, 1'b0);
        check("t1_empty_b", wbuf_empty_b, 1'b1);
        check("t1_ovf_b", wr_overflow_b, 1'b0);
        check("t1_rdata_b", rdata_b, 32'h0);
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
